// File: rtl/instr_loader.sv
// instr_loader: packs a boot byte stream into 32-bit words and writes imem.
// Define LOADER_CHECK_EN to enable header legality checking of each word.
module instr_loader #(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_illegal,
    output logic [ADDR_W-1:0] err_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RECV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [1:0]        state_nx;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W:0]   idx_inc;
    logic [1:0]        bidx;
    logic [23:0]       shift;
    logic              start_acc;
    logic              byte_acc;
    logic              wr_fire;
    logic              last_word;
    logic              len_zero;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       word;

    assign byte_ready = (state == S_RECV);
    assign start_acc  = (state == S_IDLE) && start;
    assign byte_acc   = byte_ready && byte_valid;
    assign wr_fire    = byte_acc && (bidx == 2'd3);
    assign idx_inc    = idx + ONE;
    assign last_word  = (state == S_WRITE) && (idx_inc == len_q);
    assign len_zero   = (len == '0);
    assign len_sat    = (len > MAX_LEN) ? MAX_LEN : len;
    // address arithmetic is ADDR_W wide, so it wraps past the top of imem
    assign wr_addr    = BASE_ADDR + idx[ADDR_W-1:0];
    assign word       = {byte_data, shift};

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = len_zero ? S_DONE : S_RECV;
                end
            end
            S_RECV: begin
                if (wr_fire) begin
                    state_nx = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nx = last_word ? S_DONE : S_RECV;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
            idx   <= '0;
            bidx  <= '0;
            shift <= '0;
        end else begin
            if (start_acc) begin
                len_q <= len_sat;
                idx   <= '0;
                bidx  <= '0;
            end
            if (byte_acc) begin
                bidx <= bidx + 2'd1;
                unique case (bidx)
                    2'd0:    shift[7:0]   <= byte_data;
                    2'd1:    shift[15:8]  <= byte_data;
                    2'd2:    shift[23:16] <= byte_data;
                    default: shift        <= shift;
                endcase
            end
            if (state == S_WRITE) begin
                idx <= idx_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= wr_fire;
            if (wr_fire) begin
                imem_addr  <= wr_addr;
                imem_wdata <= word;
            end
        end
    end

    // cpu_hold covers the DONE cycle; busy drops as DONE is entered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= (start_acc && len_zero) || last_word;
            if (start_acc) begin
                busy     <= !len_zero;
                cpu_hold <= 1'b1;
            end else if (last_word) begin
                busy <= 1'b0;
            end else if (state == S_DONE) begin
                cpu_hold <= 1'b0;
            end
        end
    end

`ifdef LOADER_CHECK_EN

    function automatic logic hdr_legal(input logic [5:0] h);
        logic [1:0] typ;
        logic [1:0] fn;
        logic       imm;
        logic       vec;
        logic       ok;
        typ = h[5:4];
        fn  = h[3:2];
        imm = h[1];
        vec = h[0];
        ok  = 1'b0;
        unique case (typ)
            2'b00: ok = (fn == 2'b00) || ((fn == 2'b01) && !imm);
            2'b01: ok = (fn == 2'b00) || (fn == 2'b01);
            2'b10: begin
                if (imm) begin
                    ok = !vec;
                end else begin
                    ok = (fn == 2'b00) || (fn == 2'b01) ||
                         ((fn == 2'b10) && vec);
                end
            end
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic word_bad;
    assign word_bad = wr_fire && !hdr_legal(byte_data[7:2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_illegal <= 1'b0;
            err_addr    <= '0;
        end else if (start_acc) begin
            err_illegal <= 1'b0;
            err_addr    <= '0;
        end else if (word_bad) begin
            err_illegal <= 1'b1;
            if (!err_illegal) begin
                err_addr <= wr_addr;
            end
        end
    end

`else

    assign err_illegal = 1'b0;
    assign err_addr    = '0;

`endif

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: scoreboarded imem writes,
// timing, legality flags, address wrap and asynchronous reset.
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start2;
    logic [10:0] len;
    logic        byte_valid;
    logic [7:0]  byte_data;

    logic        byte_ready, imem_we, busy, cpu_hold, done, err_illegal;
    logic [9:0]  imem_addr, err_addr;
    logic [31:0] imem_wdata;

    logic        byte_ready2, imem_we2, busy2, cpu_hold2, done2, err_illegal2;
    logic [9:0]  imem_addr2, err_addr2;
    logic [31:0] imem_wdata2;

    always #5 clk = ~clk;

`ifdef LOADER_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    instr_loader #(.ADDR_W(10), .BASE_ADDR(10'd0)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .cpu_hold(cpu_hold), .done(done),
        .err_illegal(err_illegal), .err_addr(err_addr)
    );

    instr_loader #(.ADDR_W(10), .BASE_ADDR(10'd1022)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .len(len),
        .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready2), .imem_we(imem_we2),
        .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
        .busy(busy2), .cpu_hold(cpu_hold2), .done(done2),
        .err_illegal(err_illegal2), .err_addr(err_addr2)
    );

    typedef struct {
        logic [9:0]  a;
        logic [31:0] d;
    } wr_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    wr_t  exp_q[$];
    wr_t  exp_q2[$];
    int   we_cyc[$];
    logic we_err[$];
    int   acc_cyc[$];
    int   n_w2 = 0;
    logic [7:0] bq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (byte_valid && byte_ready) acc_cyc.push_back(cyc);
        if (imem_we) begin
            we_cyc.push_back(cyc);
            we_err.push_back(err_illegal);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL wr_unexpected: got addr=%0d data=%h, want none",
                         imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.a || imem_wdata !== e.d) begin
                    n_bad++;
                    $display("FAIL wr_data: got addr=%0d data=%h, want addr=%0d data=%h",
                             imem_addr, imem_wdata, e.a, e.d);
                end
            end
        end
    end

    always @(negedge clk) begin
        wr_t e;
        if (imem_we2) begin
            n_w2++;
            n_cmp++;
            if (exp_q2.size() == 0) begin
                n_bad++;
                $display("FAIL wr2_unexpected: got addr=%0d data=%h, want none",
                         imem_addr2, imem_wdata2);
            end else begin
                e = exp_q2.pop_front();
                if (imem_addr2 !== e.a || imem_wdata2 !== e.d) begin
                    n_bad++;
                    $display("FAIL wr2_data: got addr=%0d data=%h, want addr=%0d data=%h",
                             imem_addr2, imem_wdata2, e.a, e.d);
                end
            end
        end
    end

    task automatic push_word(input logic [31:0] w, input logic [9:0] a,
                             input bit sel);
        wr_t e;
        e.a = a;
        e.d = w;
        if (sel) exp_q2.push_back(e);
        else exp_q.push_back(e);
        for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
    endtask

    task automatic do_start(input logic [10:0] l);
        @(posedge clk); #1;
        start = 1'b1;
        len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_bytes(input bit toggle, input bit sel);
        bit ph;
        bit acc;
        int guard;
        ph = 1'b1;
        guard = 0;
        while (bq.size() > 0 && guard < 300) begin
            byte_valid = toggle ? ph : 1'b1;
            byte_data = bq[0];
            @(negedge clk);
            acc = byte_valid && (sel ? byte_ready2 : byte_ready);
            @(posedge clk); #1;
            if (acc) void'(bq.pop_front());
            ph = !ph;
            guard++;
        end
        byte_valid = 1'b0;
        n_cmp++;
        if (bq.size() !== 0) begin
            n_bad++;
            $display("FAIL stream_timeout: got %0d bytes left, want 0", bq.size());
            bq.delete();
        end
    endtask

    task automatic wait_done(output int c, output bit ok);
        ok = 1'b0;
        c = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                c = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b0;
        start2 = 1'b0;
        len = '0;
        byte_valid = 1'b0;
        byte_data = '0;
        #12;
        n_cmp++;
        if ({byte_ready, imem_we, imem_addr, imem_wdata, busy, cpu_hold,
             done, err_illegal, err_addr} !== '0) begin
            n_bad++;
            $display("FAIL reset_vals: got rdy=%b we=%b addr=%0d busy=%b hold=%b done=%b err=%b, want all 0",
                     byte_ready, imem_we, imem_addr, busy, cpu_hold, done, err_illegal);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        int dc;
        bit ok;
        we_cyc.delete();
        acc_cyc.delete();
        push_word(32'h8000_0000, 10'd0, 1'b0);
        push_word(32'h4800_0001, 10'd1, 1'b0);
        do_start(11'd2);
        n_cmp++;
        if ({busy, cpu_hold} !== 2'b11) begin
            n_bad++;
            $display("FAIL b2b_busy_rise: got busy=%b hold=%b, want 1 1", busy, cpu_hold);
        end
        drive_bytes(1'b0, 1'b0);
        wait_done(dc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL b2b_done_timeout: got no done, want done");
        end
        n_cmp++;
        if (we_cyc.size() !== 2) begin
            n_bad++;
            $display("FAIL b2b_wr_count: got %0d, want 2", we_cyc.size());
        end else begin
            n_cmp++;
            if (we_cyc[1] - we_cyc[0] !== 5) begin
                n_bad++;
                $display("FAIL b2b_spacing: got %0d, want 5", we_cyc[1] - we_cyc[0]);
            end
            n_cmp++;
            if (dc !== we_cyc[1] + 1) begin
                n_bad++;
                $display("FAIL b2b_done_lat: got %0d, want %0d", dc, we_cyc[1] + 1);
            end
            n_cmp++;
            if (we_cyc[0] - acc_cyc[0] !== 4) begin
                n_bad++;
                $display("FAIL b2b_first_lat: got %0d, want 4", we_cyc[0] - acc_cyc[0]);
            end
        end
        n_cmp++;
        if ({busy, cpu_hold, err_illegal} !== 3'b010) begin
            n_bad++;
            $display("FAIL b2b_done_flags: got busy=%b hold=%b err=%b, want 0 1 0",
                     busy, cpu_hold, err_illegal);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, cpu_hold} !== 2'b00) begin
            n_bad++;
            $display("FAIL b2b_idle: got done=%b hold=%b, want 0 0", done, cpu_hold);
        end
    endtask

    task automatic test_illegal();
        int dc;
        bit ok;
        we_err.delete();
        push_word(32'hC000_0000, 10'd0, 1'b0);
        push_word(32'hA000_0000, 10'd1, 1'b0);
        push_word(32'h2C00_0000, 10'd2, 1'b0);
        do_start(11'd3);
        drive_bytes(1'b0, 1'b0);
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL ill1_writes: got done=%b left=%0d, want 1 0", ok, exp_q.size());
        end
        n_cmp++;
        if (err_illegal !== CHK || err_addr !== 10'd0) begin
            n_bad++;
            $display("FAIL ill1_flags: got err=%b addr=%0d, want %b 0",
                     err_illegal, err_addr, CHK);
        end
        n_cmp++;
        if (we_err.size() < 1 || we_err[0] !== CHK) begin
            n_bad++;
            $display("FAIL ill1_same_cycle: got %0d samples, want err=%b with first write",
                     we_err.size(), CHK);
        end
        we_err.delete();
        push_word(32'h8000_0000, 10'd0, 1'b0);
        push_word(32'hA000_0000, 10'd1, 1'b0);
        push_word(32'hFC00_0000, 10'd2, 1'b0);
        do_start(11'd3);
        n_cmp++;
        if (err_illegal !== 1'b0) begin
            n_bad++;
            $display("FAIL ill2_clear: got err=%b, want 0", err_illegal);
        end
        drive_bytes(1'b0, 1'b0);
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || err_illegal !== CHK || err_addr !== (CHK ? 10'd1 : 10'd0)) begin
            n_bad++;
            $display("FAIL ill2_first: got done=%b err=%b addr=%0d, want 1 %b %0d",
                     ok, err_illegal, err_addr, CHK, CHK ? 1 : 0);
        end
        n_cmp++;
        if (we_err.size() !== 3 || we_err[0] !== 1'b0 || we_err[1] !== CHK) begin
            n_bad++;
            $display("FAIL ill2_seq: got %0d samples, want 3 with 0,%b", we_err.size(), CHK);
        end
    endtask

    task automatic test_legal_table();
        logic [7:0] hdr[17] = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h20, 8'h44,
                                8'h5C, 8'h60, 8'h84, 8'h94, 8'hA0, 8'hA4,
                                8'hB0, 8'hB8, 8'hBC, 8'h88, 8'hF0};
        logic       lgl[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1,
                                1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int dc;
        bit ok;
        for (int i = 0; i < 17; i++) begin
            push_word({hdr[i], 24'h12_3456}, 10'd0, 1'b0);
            do_start(11'd1);
            drive_bytes(1'b0, 1'b0);
            wait_done(dc, ok);
            n_cmp++;
            if (!ok || err_illegal !== (CHK && !lgl[i])) begin
                n_bad++;
                $display("FAIL legal_tbl hdr=%h: got done=%b err=%b, want 1 %b",
                         hdr[i], ok, err_illegal, CHK && !lgl[i]);
            end
        end
    endtask

    task automatic test_len_zero();
        we_cyc.delete();
        do_start(11'd0);
        n_cmp++;
        if ({done, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL len0_done: got done=%b busy=%b, want 1 0", done, busy);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({done, busy} !== 2'b00) begin
            n_bad++;
            $display("FAIL len0_after: got done=%b busy=%b, want 0 0", done, busy);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (we_cyc.size() !== 0 || byte_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL len0_nowrite: got writes=%0d rdy=%b, want 0 0",
                     we_cyc.size(), byte_ready);
        end
    endtask

    task automatic test_base_wrap();
        bit ok;
        n_w2 = 0;
        push_word(32'h8000_0011, 10'd1022, 1'b1);
        push_word(32'h8400_0022, 10'd1023, 1'b1);
        push_word(32'h4000_0033, 10'd0, 1'b1);
        @(posedge clk); #1;
        start2 = 1'b1;
        len = 11'd3;
        @(posedge clk); #1;
        start2 = 1'b0;
        drive_bytes(1'b0, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done2 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!ok || n_w2 !== 3 || exp_q2.size() !== 0) begin
            n_bad++;
            $display("FAIL wrap_writes: got done=%b writes=%0d left=%0d, want 1 3 0",
                     ok, n_w2, exp_q2.size());
        end
    endtask

    task automatic test_toggle();
        int dc;
        bit ok;
        we_cyc.delete();
        acc_cyc.delete();
        push_word(32'h1020_3040, 10'd0, 1'b0);
        do_start(11'd1);
        fork
            drive_bytes(1'b1, 1'b0);
            begin
                repeat (3) @(posedge clk);
                #1;
                start = 1'b1;
                len = 11'd5;
                @(posedge clk); #1;
                start = 1'b0;
            end
        join
        wait_done(dc, ok);
        byte_valid = 1'b1;
        byte_data = 8'h5A;
        repeat (6) @(negedge clk);
        byte_valid = 1'b0;
        n_cmp++;
        if (!ok || acc_cyc.size() !== 4 || we_cyc.size() !== 1) begin
            n_bad++;
            $display("FAIL toggle_counts: got done=%b bytes=%0d writes=%0d, want 1 4 1",
                     ok, acc_cyc.size(), we_cyc.size());
        end else begin
            n_cmp++;
            if (we_cyc[0] - acc_cyc[0] !== 7) begin
                n_bad++;
                $display("FAIL toggle_lat: got %0d, want 7", we_cyc[0] - acc_cyc[0]);
            end
        end
        n_cmp++;
        if ({busy, cpu_hold, byte_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL toggle_ignored_start: got busy=%b hold=%b rdy=%b, want 0 0 0",
                     busy, cpu_hold, byte_ready);
        end
    endtask

    task automatic test_reset_midload();
        int dc;
        bit ok;
        we_cyc.delete();
        bq.push_back(8'h44);
        bq.push_back(8'h33);
        do_start(11'd2);
        drive_bytes(1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({byte_ready, imem_we, imem_addr, imem_wdata, busy, cpu_hold,
             done, err_illegal, err_addr} !== '0) begin
            n_bad++;
            $display("FAIL midrst_vals: got rdy=%b busy=%b hold=%b wdata=%h err=%b, want all 0",
                     byte_ready, busy, cpu_hold, imem_wdata, err_illegal);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (we_cyc.size() !== 0) begin
            n_bad++;
            $display("FAIL midrst_nowrite: got %0d writes, want 0", we_cyc.size());
        end
        push_word(32'h8000_BEEF, 10'd0, 1'b0);
        do_start(11'd1);
        drive_bytes(1'b0, 1'b0);
        wait_done(dc, ok);
        n_cmp++;
        if (!ok || we_cyc.size() !== 1 || exp_q.size() !== 0) begin
            n_bad++;
            $display("FAIL midrst_reload: got done=%b writes=%0d left=%0d, want 1 1 0",
                     ok, we_cyc.size(), exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_illegal();
        test_legal_table();
        test_len_zero();
        test_base_wrap();
        test_toggle();
        test_reset_midload();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction loader for the vector core. It accepts a byte stream over a valid/ready handshake and packs the bytes into 32-bit instruction words. Each word is written into instruction memory at consecutive addresses while the core is held in reset. Optionally, the loader checks every word's header fields (`instruction_type`, `func`, `imm`, `vector`) against the encodings the control unit decodes, and flags illegal words.

## Interface
Parameters:
- `ADDR_W`, 10: instruction memory address width (words).
- `BASE_ADDR`, 0: first write address; `ADDR_W` bits.

Ports:
- `clk` in 1: core clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset); release is synchronous to `clk` at SoC level.
- `start` in 1: pulse; begins a load; honoured only in IDLE.
- `len` in ADDR_W+1: number of words to load; sampled on an accepted `start`.
- `byte_valid` in 1: `byte_data` valid.
- `byte_data` in 8: stream byte.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `imem_we` out 1: instruction memory write strobe.
- `imem_addr` out ADDR_W: write address.
- `imem_wdata` out 32: write data.
- `busy` out 1: load in progress (RECV or WRITE).
- `cpu_hold` out 1: holds the core in reset.
- `done` out 1: one-cycle pulse at the end of a load.
- `err_illegal` out 1: sticky flag, set when an illegal word is written; cleared by an accepted `start`.
- `err_addr` out ADDR_W: address of the first illegal word of the current load.

## Operation
- FSM states: IDLE, RECV, WRITE, DONE.
- **IDLE**
  - On `start`: latch `len`, saturated to 2^ADDR_W; clear `err_illegal`; set `err_addr`=0; set word index=0; set byte index=0.
  - Next state is RECV, or DONE when `len`=0.
- **RECV**
  - `byte_ready`=1; a byte is accepted when `byte_valid`&`byte_ready`.
  - Packing is little-endian: byte k goes to bits [8k+7:8k].
  - After the 4th accepted byte: next state WRITE.
- **WRITE**
  - `imem_we`=1 for exactly one cycle.
  - `imem_addr`=(BASE_ADDR+index) mod 2^ADDR_W, so the address wraps silently.
  - The word is always written, legal or not.
  - Then increment index. If index reaches len: go to DONE, else go to RECV.
- **DONE**
  - `done`=1 for one cycle; then IDLE.
- Header fields: [31:30] `instruction_type`, [29:28] `func`, [27] `imm`, [26] `vector`.
- Legal encodings:
  - type 00: (func 00, imm 0); (func 00, imm 1); (func 01, imm 0); `vector` don't-care.
  - type 01: func 00 or 01; `imm` and `vector` don't-care.
  - type 10, imm 0: func 00 or 01 with any `vector`; func 10 only with `vector`=1.
  - type 10, imm 1: any func, with `vector`=0.
  - type 11: always illegal.
  - Everything else is illegal.
- `start` outside IDLE is ignored.
- `byte_valid` outside RECV is ignored; the byte is not consumed.
- Reset mid-load:
  - Immediately abort to IDLE; the partial word is discarded.
  - Memory already written is left as is.
  - `cpu_hold` drops; software must reload.

## Timing
- Reset values:
  - FSM=IDLE.
  - `byte_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0.
  - `busy`=0, `cpu_hold`=0, `done`=0, `err_illegal`=0, `err_addr`=0.
- All outputs are registered, except `byte_ready`, which decodes directly from state.
- `busy` and `cpu_hold` rise the cycle after an accepted `start`.
  - `busy` falls on entry to DONE.
  - `cpu_hold` stays high through the DONE cycle and falls with the return to IDLE.
- Throughput: with `byte_valid` held high, one word takes 5 cycles (4 RECV + 1 WRITE).
- Latency: `done` is asserted the cycle after the final WRITE.
- With `len`=0: `done` is asserted the cycle after `start`; there is no write and `busy` stays 0.
- Error reporting: `err_illegal` and `err_addr` update in the same cycle as the offending `imem_we`. `err_addr` records only the first offender of a load.

## Configuration
- Macro: `LOADER_CHECK_EN`.
- Defined: legality check, `err_illegal` and `err_addr` behave as above.
- Undefined: the check logic is omitted; `err_illegal` and `err_addr` are tied to 0. All other behaviour and timing are identical.

## Test plan
- `start`, `len`=2, bytes 00 00 00 80, 01 00 00 48 streamed back-to-back:
  - `imem_we` at addr 0 data 0x80000000, then addr 1 data 0x48000001.
  - Writes are 5 cycles apart; `done` one cycle later.
  - `err_illegal`=0.
- `len`=3, words 0xC0000000, 0xA0000000, 0x2C000000 (with check enabled):
  - All three words are written.
  - `err_illegal`=1 and `err_addr`=0.
  - Without the macro: `err_illegal`=0.
- `len`=0:
  - `done` is asserted the cycle after `start`; no `imem_we`; `busy` stays 0.
- `BASE_ADDR`=1022, `ADDR_W`=10, `len`=3: writes go to addresses 1022, 1023, 0.
- `byte_valid` toggling 1/0 each cycle, `len`=1:
  - Exactly 4 bytes are consumed; the write lands 7 cycles after the first byte.
  - A second `start` during the load is ignored.
- `rst`=0 after the 2nd byte of a word:
  - All outputs return to reset values asynchronously; no `imem_we`.
  - A following load starts again at `BASE_ADDR`.
